// File: rtl/writeback_buffer.sv
// writeback_buffer: FIFO of evicted dirty lines waiting for the memory write port.
// Non-head entries with the same line address merge in place. A lookup port
// lets the miss handler refill a line from the buffer instead of reading stale
// memory.
module writeback_buffer #(
  parameter int DEPTH   = 4,
  parameter int LADDR_W = 28,
  parameter int LINE_W  = 128,
  parameter int OFFS_W  = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LADDR_W-1:0]        in_addr,
  input  logic [LINE_W-1:0]         in_data,
  input  logic [LADDR_W-1:0]        lk_addr,
  output logic                      lk_hit,
  output logic [LINE_W-1:0]         lk_data,
  output logic                      mem_dvalid,
  input  logic                      mem_mready,
  output logic                      mem_wen,
  output logic [LADDR_W+OFFS_W-1:0] mem_addr,
  output logic [LINE_W-1:0]         mem_data,
  output logic                      busy,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LADDR_W-1:0] addrArr_q [DEPTH];
  logic [LINE_W-1:0]  dataArr_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               mergeHit;
  logic [PTR_W-1:0]   mergeIdx;
  logic               accept;
  logic               alloc;
  logic               drain;
  logic               headHit;
  logic               otherHit;
  logic [LINE_W-1:0]  otherData;

  // Find the single non-head entry that an incoming line would merge into;
  // the head is skipped because it may already be on the memory bus.
  always_comb begin
    mergeHit = 1'b0;
    mergeIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (PTR_W'(i) != head_q) && (addrArr_q[i] == in_addr)) begin
        mergeHit = 1'b1;
        mergeIdx = PTR_W'(i);
      end
    end
  end

  // Lookup prefers the non-head match, which is always the younger copy.
  always_comb begin
    headHit   = valid_q[head_q] && (addrArr_q[head_q] == lk_addr);
    otherHit  = 1'b0;
    otherData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (PTR_W'(i) != head_q) && (addrArr_q[i] == lk_addr)) begin
        otherHit  = 1'b1;
        otherData = dataArr_q[i];
      end
    end
  end

  assign lk_hit     = headHit | otherHit;
  assign lk_data    = otherHit ? otherData : dataArr_q[head_q];

  assign full       = (count_q == CNT_W'(DEPTH));
  assign in_ready   = !full | mergeHit;
  assign mem_dvalid = (count_q != '0);
  assign busy       = mem_dvalid;
  assign mem_wen    = 1'b1;
  assign mem_addr   = {addrArr_q[head_q], {OFFS_W{1'b0}}};
  assign mem_data   = dataArr_q[head_q];

  assign accept     = in_valid & in_ready;
  assign alloc      = accept & !mergeHit;
  assign drain      = mem_dvalid & mem_mready;

  // Next pointers, valid bits and occupancy from this cycle's allocate/drain.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (alloc && !drain) begin
      count_d = count_q + CNT_W'(1);
    end else if (!alloc && drain) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addrArr_q[tail_q] <= in_addr;
      dataArr_q[tail_q] <= in_data;
    end else if (accept && mergeHit) begin
      dataArr_q[mergeIdx] <= in_data;
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: scenario tasks plus a randomized run, all checked
// against a queue-based model of the buffer's FIFO/merge behaviour.
module tb_writeback_buffer;

  localparam int DEPTH   = 4;
  localparam int LADDR_W = 28;
  localparam int LINE_W  = 128;
  localparam int OFFS_W  = 4;

  typedef struct packed {
    logic [LADDR_W-1:0] addr;
    logic [LINE_W-1:0]  data;
  } entry_t;

  logic                      clk;
  logic                      resetn;
  logic                      in_valid;
  logic                      in_ready;
  logic [LADDR_W-1:0]        in_addr;
  logic [LINE_W-1:0]         in_data;
  logic [LADDR_W-1:0]        lk_addr;
  logic                      lk_hit;
  logic [LINE_W-1:0]         lk_data;
  logic                      mem_dvalid;
  logic                      mem_mready;
  logic                      mem_wen;
  logic [LADDR_W+OFFS_W-1:0] mem_addr;
  logic [LINE_W-1:0]         mem_data;
  logic                      busy;
  logic                      full;

  int testsRun;
  int testsFailed;

  // Reference model: index 0 is the head, back of the queue is the youngest.
  entry_t modelQ[$];
  logic   expAccept;
  logic   expDrain;

  writeback_buffer #(
    .DEPTH(DEPTH), .LADDR_W(LADDR_W), .LINE_W(LINE_W), .OFFS_W(OFFS_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .mem_dvalid(mem_dvalid), .mem_mready(mem_mready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted when there is room, or when a younger-than-head copy exists.
  function automatic logic modelInReady(input logic [LADDR_W-1:0] a);
    if (modelQ.size() < DEPTH) return 1'b1;
    for (int i = 1; i < modelQ.size(); i++)
      if (modelQ[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // Youngest matching entry wins.
  function automatic logic modelLkHit(input logic [LADDR_W-1:0] a);
    foreach (modelQ[i]) if (modelQ[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [LINE_W-1:0] modelLkData(input logic [LADDR_W-1:0] a);
    logic [LINE_W-1:0] d;
    d = '0;
    foreach (modelQ[i]) if (modelQ[i].addr == a) d = modelQ[i].data;
    return d;
  endfunction

  function automatic logic [LINE_W-1:0] randLine();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive inputs after the falling edge and predict what the next edge does.
  task automatic applyStimulus(input logic v, input logic [LADDR_W-1:0] a,
                               input logic [LINE_W-1:0] d, input logic r,
                               input logic [LADDR_W-1:0] lk);
    @(negedge clk);
    in_valid   = v;
    in_addr    = a;
    in_data    = d;
    mem_mready = r;
    lk_addr    = lk;
    #1;
    expAccept = v && modelInReady(a);
    expDrain  = (modelQ.size() > 0) && r;
  endtask

  // Clock edge: apply the predicted merge/allocate, then the drain.
  task automatic tick();
    int idx;
    @(posedge clk);
    if (expAccept) begin
      idx = -1;
      for (int i = 1; i < modelQ.size(); i++)
        if (modelQ[i].addr == in_addr) idx = i;
      if (idx > 0) modelQ[idx].data = in_data;
      else modelQ.push_back('{addr: in_addr, data: in_data});
    end
    if (expDrain) void'(modelQ.pop_front());
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_data = '0; mem_mready = 1'b0; lk_addr = '0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (mem_dvalid !== 1'b0 || busy !== 1'b0 || full !== 1'b0 || in_ready !== 1'b1 ||
        lk_hit !== 1'b0 || mem_wen !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: dvalid=%b busy=%b full=%b in_ready=%b lk_hit=%b wen=%b, required 0 0 0 1 0 1",
               mem_dvalid, busy, full, in_ready, lk_hit, mem_wen);
    end
    resetn = 1'b1;
    modelQ.delete();
  endtask

  task automatic test_single();
    logic [LINE_W-1:0] lineA;
    lineA = randLine();
    applyStimulus(1'b1, 28'h0000123, lineA, 1'b0, 28'h0000123);
    testsRun++;
    if (in_ready !== 1'b1 || lk_hit !== 1'b0 || mem_dvalid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_enqueue: in_ready=%b lk_hit=%b dvalid=%b, required 1 0 0",
               in_ready, lk_hit, mem_dvalid);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 28'h0000123);
      testsRun++;
      if (mem_dvalid !== 1'b1 || mem_addr !== 32'h00001230 || mem_data !== lineA ||
          lk_hit !== 1'b1 || lk_data !== lineA) begin
        testsFailed++;
        $display("[TB] FAIL single_stall%0d: dvalid=%b addr=%h data=%h lk_hit=%b, required 1 00001230 %h 1",
                 c, mem_dvalid, mem_addr, mem_data, lk_hit, lineA);
      end
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, '0);
    tick();
    idle();
    testsRun++;
    if (mem_dvalid !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_drained: dvalid=%b busy=%b, required 0 0", mem_dvalid, busy);
    end
    tick();
  endtask

  task automatic test_fill_full(input logic [LADDR_W-1:0] base);
    logic [LINE_W-1:0] lines [4];
    for (int k = 0; k < 4; k++) begin
      lines[k] = randLine();
      applyStimulus(1'b1, base + LADDR_W'(k), lines[k], 1'b0, '0);
      tick();
    end
    applyStimulus(1'b1, base + LADDR_W'(4), randLine(), 1'b0, '0);
    testsRun++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fill_full base %h: full=%b in_ready=%b, required 1 0", base, full, in_ready);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, '0);
      testsRun++;
      if (mem_dvalid !== 1'b1 || mem_addr !== {base + LADDR_W'(k), 4'h0} || mem_data !== lines[k]) begin
        testsFailed++;
        $display("[TB] FAIL fill_drain%0d: dvalid=%b addr=%h data=%h, required 1 %h %h",
                 k, mem_dvalid, mem_addr, mem_data, {base + LADDR_W'(k), 4'h0}, lines[k]);
      end
      tick();
    end
    idle();
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fill_empty: busy=%b, required 0", busy);
    end
    tick();
  endtask

  task automatic test_merge();
    logic [LINE_W-1:0] lA, lB, lC, lC2, l22, l23;
    logic [LADDR_W-1:0] expAddr [4];
    logic [LINE_W-1:0]  expData [4];
    lA = randLine(); lB = randLine(); lC = randLine(); lC2 = randLine();
    l22 = randLine(); l23 = randLine();
    applyStimulus(1'b1, 28'h20, lA, 1'b0, '0); tick();
    applyStimulus(1'b1, 28'h21, lB, 1'b0, '0); tick();
    applyStimulus(1'b1, 28'h21, lC, 1'b0, '0); tick();
    applyStimulus(1'b1, 28'h22, l22, 1'b0, '0); tick();
    applyStimulus(1'b1, 28'h23, l23, 1'b0, 28'h21);
    testsRun++;
    if (full !== 1'b0 || lk_hit !== 1'b1 || lk_data !== lC) begin
      testsFailed++;
      $display("[TB] FAIL merge_count: full=%b lk_hit=%b lk_data=%h, required 0 1 %h", full, lk_hit, lk_data, lC);
    end
    tick();
    applyStimulus(1'b1, 28'h21, lC2, 1'b0, '0);
    testsRun++;
    if (full !== 1'b1 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL merge_when_full: full=%b in_ready=%b, required 1 1", full, in_ready);
    end
    tick();
    expAddr = '{28'h20, 28'h21, 28'h22, 28'h23};
    expData = '{lA, lC2, l22, l23};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, '0);
      testsRun++;
      if (mem_dvalid !== 1'b1 || mem_addr !== {expAddr[k], 4'h0} || mem_data !== expData[k]) begin
        testsFailed++;
        $display("[TB] FAIL merge_drain%0d: dvalid=%b addr=%h data=%h, required 1 %h %h",
                 k, mem_dvalid, mem_addr, mem_data, {expAddr[k], 4'h0}, expData[k]);
      end
      tick();
    end
  endtask

  task automatic test_head_not_merged();
    logic [LINE_W-1:0] lA, lB;
    lA = randLine(); lB = randLine();
    applyStimulus(1'b1, 28'h30, lA, 1'b0, '0); tick();
    applyStimulus(1'b1, 28'h30, lB, 1'b0, '0); tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 28'h30);
    testsRun++;
    if (lk_hit !== 1'b1 || lk_data !== lB || mem_data !== lA) begin
      testsFailed++;
      $display("[TB] FAIL head_lookup: lk_hit=%b lk_data=%h head=%h, required 1 %h %h",
               lk_hit, lk_data, mem_data, lB, lA);
    end
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, '0);
    testsRun++;
    if (mem_dvalid !== 1'b1 || mem_addr !== 32'h00000300 || mem_data !== lB) begin
      testsFailed++;
      $display("[TB] FAIL head_second: dvalid=%b addr=%h data=%h, required 1 00000300 %h",
               mem_dvalid, mem_addr, mem_data, lB);
    end
    tick();
    idle();
    testsRun++;
    if (mem_dvalid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL head_count2: dvalid=%b, required 0", mem_dvalid);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 28'h50 + LADDR_W'(k), randLine(), 1'b0, '0); tick();
    end
    applyStimulus(1'b1, 28'h54, randLine(), 1'b1, '0);
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL simul_full_refuse: in_ready=%b, required 0", in_ready);
    end
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, '0); tick();
    applyStimulus(1'b1, 28'h55, randLine(), 1'b1, '0);
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL simul_accept: in_ready=%b, required 1", in_ready);
    end
    tick();
    applyStimulus(1'b1, 28'h56, randLine(), 1'b0, '0); tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 28'h54);
    testsRun++;
    if (full !== 1'b0 || lk_hit !== 1'b0 || mem_addr !== 32'h00000530) begin
      testsFailed++;
      $display("[TB] FAIL simul_count3: full=%b lk_hit=%b addr=%h, required 0 0 00000530", full, lk_hit, mem_addr);
    end
    tick();
    applyStimulus(1'b1, 28'h57, randLine(), 1'b0, '0); tick();
    idle();
    testsRun++;
    if (full !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL simul_count4: full=%b, required 1", full);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, '0);
      testsRun++;
      if (mem_addr !== {modelQ[0].addr, 4'h0} || mem_data !== modelQ[0].data) begin
        testsFailed++;
        $display("[TB] FAIL simul_drain%0d: addr=%h data=%h, required %h %h",
                 k, mem_addr, mem_data, {modelQ[0].addr, 4'h0}, modelQ[0].data);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [LADDR_W-1:0] a, lk;
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      a  = 28'h60 + LADDR_W'($urandom_range(0, 5));
      lk = 28'h60 + LADDR_W'($urandom_range(0, 6));
      applyStimulus(1'($urandom_range(0, 1)), a, randLine(), ($urandom_range(0, 2) == 0), lk);
      testsRun++;
      if (in_ready !== modelInReady(a) || full !== (modelQ.size() == DEPTH) ||
          busy !== (modelQ.size() > 0) || mem_dvalid !== (modelQ.size() > 0) ||
          lk_hit !== modelLkHit(lk) || mem_wen !== 1'b1 ||
          (modelQ.size() > 0 && (mem_addr !== {modelQ[0].addr, 4'h0} || mem_data !== modelQ[0].data)) ||
          (modelLkHit(lk) && lk_data !== modelLkData(lk))) begin
        testsFailed++;
        if (errs < 10)
          $display("[TB] FAIL random_cycle%0d: in_ready=%b full=%b dvalid=%b lk_hit=%b addr=%h, required %b %b %b %b size=%0d",
                   c, in_ready, full, mem_dvalid, lk_hit, mem_addr, modelInReady(a),
                   (modelQ.size() == DEPTH), (modelQ.size() > 0), modelLkHit(lk), modelQ.size());
        errs++;
      end
      tick();
    end
    for (int c = 0; c < DEPTH; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, '0); tick();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 28'h70 + LADDR_W'(k), randLine(), 1'b0, 28'h71); tick();
    end
    #1;
    testsRun++;
    if (mem_dvalid !== 1'b1 || lk_hit !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL areset_pre: dvalid=%b lk_hit=%b, required 1 1", mem_dvalid, lk_hit);
    end
    #2 resetn = 1'b0;
    #1;
    testsRun++;
    if (mem_dvalid !== 1'b0 || busy !== 1'b0 || lk_hit !== 1'b0 || in_ready !== 1'b1 || mem_wen !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL areset_drop: dvalid=%b busy=%b lk_hit=%b in_ready=%b wen=%b, required 0 0 0 1 1",
               mem_dvalid, busy, lk_hit, in_ready, mem_wen);
    end
    modelQ.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expAccept   = 1'b0;
    expDrain    = 1'b0;
    test_reset();
    test_single();
    test_fill_full(28'h10);
    test_fill_full(28'h40);
    test_merge();
    test_head_not_merged();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Parametrised multi-entry write-back buffer between the D-cache miss handler and the memory write port. It accepts evicted dirty cache lines, queues up to DEPTH of them in FIFO order, and drains them to memory one line per `mready` handshake. Writes to a line already queued (not at the head) merge in place. A lookup port lets the miss handler refill a line directly from the buffer instead of reading stale memory.

## Interface
Parameters:
- `DEPTH`, 4: entries; power of two, ≥2.
- `LADDR_W`, 28: line address width.
- `LINE_W`, 128: line data width.
- `OFFS_W`, 4: byte-offset bits appended (as zeros) to the memory address.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  miss handler offers a line.
- `in_ready`  out  1  line accepted when `in_valid & in_ready`.
- `in_addr`  in  LADDR_W  line address.
- `in_data`  in  LINE_W  line data.
- `lk_addr`  in  LADDR_W  lookup address (combinational).
- `lk_hit`  out  1  `lk_addr` matches a queued entry.
- `lk_data`  out  LINE_W  data of the youngest matching entry; don't-care when `lk_hit=0`.
- `mem_dvalid`  out  1  head entry presented to memory.
- `mem_mready`  in  1  memory accepts the presented line.
- `mem_wen`  out  1  constant 1.
- `mem_addr`  out  LADDR_W+OFFS_W  `{head_addr, OFFS_W'b0}`.
- `mem_data`  out  LINE_W  head data.
- `busy`  out  1  buffer non-empty (equals `mem_dvalid`).
- `full`  out  1  count == DEPTH.

## Operation
- State: circular array of DEPTH {addr, data, valid}; `head`/`tail` pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; `count` of $clog2(DEPTH+1) bits.
- Head entry: while count>0, the entry at `head` drives `mem_*` and `mem_dvalid=1`. Its addr/data stay stable until `mem_mready`. On `mem_dvalid & mem_mready`, the entry is invalidated, `head` increments, and `count` decrements.
- Merge: `merge_hit` = a valid non-head entry has addr == `in_addr`. On acceptance with `merge_hit`, that entry's data is overwritten. Count and tail do not change. The head entry is never merged into: a match on the head only allocates a new entry.
- Allocate: on acceptance without `merge_hit`, write `{in_addr, in_data}` at `tail`, increment `tail`, and increment `count`.
- `in_ready = (count < DEPTH) | merge_hit`. It depends only on the current state: a same-cycle drain does not free a slot for the current cycle.
- Same-cycle allocate and drain: `count` is unchanged and both pointers advance.
- Lookup: a non-head match wins over a head match. At most one non-head match can exist, because merging guarantees it.
- The buffer has no bypass. An accepted line reaches `mem_*` no earlier than the next cycle.

## Timing
- Reset (async assert, sync release): `count=0`, `head=tail=0`, all valid=0. Consequently `mem_dvalid=0`, `busy=0`, `full=0`, `in_ready=1`, `lk_hit=0`. Data/addr arrays are not reset.
- Reset asserted mid-transfer: queued lines are dropped and `mem_dvalid` falls immediately.
- Enqueue-to-memory latency: 1 cycle from acceptance when the buffer was empty.
- Drain throughput: 1 line/cycle while `mem_mready=1`.
- Lookup reflects state after the last clock edge. A line being accepted in the current cycle is not visible to lookup until the next cycle.
- `mem_wen=1` at all times, including reset.

## Test plan
- Single line: enqueue addr 0x0000123, data A with `mem_mready=0` for 3 cycles. Required: `mem_dvalid=1` from the next cycle, `mem_addr=0x00001230` and `mem_data=A` stable throughout. Then `mem_mready=1` → `mem_dvalid=0` and `busy=0` the cycle after.
- Fill/full: 4 distinct addrs 0x10–0x13 with memory stalled. Required: `full=1`, `in_ready=0` for new addr 0x14. Release `mem_mready` → drains 0x10,0x11,0x12,0x13 in order on consecutive cycles. Pointers wrap correctly on a second fill.
- Merge: queue 0x20(A), 0x21(B) with memory stalled, then 0x21(C). Required: count stays 2 and the drain order is 0x20(A), 0x21(C). With the buffer full, `in_ready=1` for 0x21.
- Head not merged: queue 0x30(A) stalled, then 0x30(B). Required: count=2, drain order 0x30(A) then 0x30(B). `lk_addr=0x30` returns B.
- Simultaneous: buffer full, `mem_mready=1` and `in_valid` with a new addr in the same cycle. Required: enqueue refused that cycle. With count=2, accept plus drain in the same cycle keeps count=2.
- Async reset with 3 entries queued and `mem_dvalid=1`: assert `resetn=0` mid-cycle. Required: `mem_dvalid`, `busy`, `lk_hit` drop to 0 without a clock edge, and `in_ready=1`.
